// File: rtl/s208_rate_ctrl.sv
// s208 rate controller: Y state counter, latched rate word and the registered Z pulse decode.
// Optional Z pulse counter on zcount is enabled by defining S208_ZCOUNT_EN.
module s208_rate_ctrl #(
    parameter int LEN_W = 16
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [8:0]       cfg_rate,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_clr,
    input  logic             X,
    input  logic             abort,
    output logic             Z,
    output logic [7:0]       Y,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] zcount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [8:0]       rate_q;
    logic [LEN_W-1:0] remaining_q;
    logic             accept;
    logic             tick;
    logic [7:0]       y_low;
    logic             z_next;

    assign cfg_ready = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign accept    = cfg_valid && (state_q == IDLE);
    assign tick      = X && (state_q == RUN);

    // Isolating the lowest set bit of Y makes the k>=1 terms one-hot, so each
    // C_k simply gates one bit of y_low.
    assign y_low  = Y & (~Y + 8'd1);
    assign z_next = tick && (rate_q[0] || (|(rate_q[8:1] & y_low)));

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (cfg_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort || (X && (remaining_q == LEN_W'(1)))) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Y is only cleared on request so the fractional phase carries across runs.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            Y           <= 8'd0;
            rate_q      <= 9'd0;
            remaining_q <= '0;
            Z           <= 1'b0;
        end else begin
            Z <= z_next;
            if (accept) begin
                rate_q      <= cfg_rate;
                remaining_q <= cfg_len;
                if (cfg_clr) begin
                    Y <= 8'd0;
                end
            end else if (tick) begin
                Y           <= Y + 8'd1;
                remaining_q <= remaining_q - LEN_W'(1);
            end
        end
    end

`ifdef S208_ZCOUNT_EN
    logic [LEN_W-1:0] zcount_q;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            zcount_q <= '0;
        end else if (accept) begin
            zcount_q <= '0;
        end else if (z_next && (zcount_q != '1)) begin
            zcount_q <= zcount_q + LEN_W'(1);
        end
    end

    assign zcount = zcount_q;
`else
    assign zcount = '0;
`endif

endmodule

// File: tb/tb_s208_rate_ctrl.sv
// Directed bench for s208_rate_ctrl: table of full runs plus abort and mid-run reset sequences.
module tb_s208_rate_ctrl;

    localparam int LEN_W = 16;

    logic             CK = 1'b0;
    logic             RST;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [8:0]       cfg_rate;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_clr;
    logic             X;
    logic             abort;
    logic             Z;
    logic [7:0]       Y;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] zcount;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic [8:0]  rate;
        logic [15:0] len;
        logic        clr;
        logic        toggle;
        int          pulses;
        logic [7:0]  y_end;
        int          cycles;
        logic [7:0]  pmask;
        logic [7:0]  pval;
    } vec_t;

    vec_t vecs [7];

    s208_rate_ctrl #(.LEN_W(LEN_W)) dut (
        .CK        (CK),
        .RST       (RST),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_rate  (cfg_rate),
        .cfg_len   (cfg_len),
        .cfg_clr   (cfg_clr),
        .X         (X),
        .abort     (abort),
        .Z         (Z),
        .Y         (Y),
        .busy      (busy),
        .done      (done),
        .zcount    (zcount)
    );

    always #5 CK = ~CK;

    function automatic int zexp(input int n);
`ifdef S208_ZCOUNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic offerConfig(input logic [8:0] rate, input logic [15:0] len, input logic clr);
        @(negedge CK);
        checkOutput("cfg_ready before offer", 32'(cfg_ready), 32'd1);
        cfg_rate  = rate;
        cfg_len   = len;
        cfg_clr   = clr;
        cfg_valid = 1'b1;
        X         = 1'b0;
        @(negedge CK);
        cfg_valid = 1'b0;
    endtask

    // A pulse observed together with Y came from the tick taken at Y-1.
    task automatic applyStimulus(input vec_t v, input string tag);
        int         cycles  = 0;
        int         pulses  = 0;
        bit         pos_ok  = 1'b1;
        bit         timeout = 1'b0;
        logic [7:0] py;
        offerConfig(v.rate, v.len, v.clr);
        forever begin
            if (Z) begin
                pulses++;
                py = Y - 8'd1;
                if ((py & v.pmask) != v.pval) pos_ok = 1'b0;
            end
            if (done) break;
            if (cycles >= 600) begin
                timeout = 1'b1;
                break;
            end
            cycles++;
            X = v.toggle ? cycles[0] : 1'b1;
            @(negedge CK);
        end
        X = 1'b0;
        checkOutput({tag, " timeout"}, 32'(timeout), 32'd0);
        checkOutput({tag, " done cycle"}, 32'(cycles), 32'(v.cycles));
        checkOutput({tag, " pulses"}, 32'(pulses), 32'(v.pulses));
        checkOutput({tag, " pulse position"}, 32'(pos_ok), 32'd1);
        checkOutput({tag, " Y end"}, 32'(Y), 32'(v.y_end));
        checkOutput({tag, " zcount"}, 32'(zcount), 32'(zexp(v.pulses)));
        @(negedge CK);
        checkOutput({tag, " done width"}, 32'(done), 32'd0);
        checkOutput({tag, " back to idle"}, 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        int   pulses;
        bit   seen_done;
        vec_t resume_v;

        vecs[0] = '{9'h100, 16'd256, 1'b1, 1'b0, 1,   8'h00, 256, 8'hFF, 8'h80};
        vecs[1] = '{9'h002, 16'd256, 1'b1, 1'b0, 128, 8'h00, 256, 8'h01, 8'h01};
        vecs[2] = '{9'h1FF, 16'd256, 1'b1, 1'b0, 256, 8'h00, 256, 8'h00, 8'h00};
        vecs[3] = '{9'h010, 16'd20,  1'b1, 1'b1, 1,   8'd20,  39,  8'hFF, 8'h08};
        vecs[4] = '{9'h001, 16'd0,   1'b0, 1'b0, 0,   8'd20,  0,   8'h00, 8'h00};
        vecs[5] = '{9'h004, 16'd8,   1'b0, 1'b0, 2,   8'd28,  8,   8'h03, 8'h02};
        vecs[6] = '{9'h180, 16'd256, 1'b0, 1'b0, 3,   8'd28,  256, 8'h3F, 8'h00};

        RST       = 1'b1;
        cfg_valid = 1'b0;
        cfg_rate  = 9'd0;
        cfg_len   = '0;
        cfg_clr   = 1'b0;
        X         = 1'b0;
        abort     = 1'b0;
        @(negedge CK);
        checkOutput("reset Z", 32'(Z), 32'd0);
        checkOutput("reset Y", 32'(Y), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("reset zcount", 32'(zcount), 32'd0);
        RST = 1'b0;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort on the 11th tick: that tick still counts, then DONE.
        offerConfig(9'h001, 16'd100, 1'b1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            X = 1'b1;
            @(negedge CK);
            if (Z) pulses++;
        end
        checkOutput("abort pre busy", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge CK);
        if (Z) pulses++;
        abort = 1'b0;
        X     = 1'b0;
        checkOutput("abort done", 32'(done), 32'd1);
        checkOutput("abort Y", 32'(Y), 32'd11);
        checkOutput("abort pulses", 32'(pulses), 32'd11);
        checkOutput("abort zcount", 32'(zcount), 32'(zexp(11)));
        @(negedge CK);
        checkOutput("abort done width", 32'(done), 32'd0);
        abort = 1'b1;
        @(negedge CK);
        abort = 1'b0;
        checkOutput("abort in idle ignored", 32'(cfg_ready), 32'd1);
        checkOutput("abort in idle Y", 32'(Y), 32'd11);
        resume_v = '{9'h001, 16'd5, 1'b0, 1'b0, 5, 8'd16, 5, 8'h00, 8'h00};
        applyStimulus(resume_v, "resume");

        // Asynchronous reset between edges in the middle of a run.
        offerConfig(9'h1FF, 16'd100, 1'b1);
        X = 1'b1;
        repeat (5) @(negedge CK);
        checkOutput("midrun Z before reset", 32'(Z), 32'd1);
        checkOutput("midrun busy before reset", 32'(busy), 32'd1);
        #2 RST = 1'b1;
        #1;
        checkOutput("midrun reset Z", 32'(Z), 32'd0);
        checkOutput("midrun reset Y", 32'(Y), 32'd0);
        checkOutput("midrun reset busy", 32'(busy), 32'd0);
        checkOutput("midrun reset done", 32'(done), 32'd0);
        checkOutput("midrun reset cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("midrun reset zcount", 32'(zcount), 32'd0);
        @(negedge CK);
        RST = 1'b0;
        X   = 1'b0;
        seen_done = 1'b0;
        repeat (5) begin
            @(negedge CK);
            if (done) seen_done = 1'b1;
        end
        checkOutput("midrun no done pulse", 32'(seen_done), 32'd0);
        checkOutput("midrun idle after reset", 32'(cfg_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/s208_rate_ctrl.md
Name: s208_rate_ctrl

Overview:
- Sequential controller for the s208 fractional-multiplier Z datapath.
- Owns the Y_1..Y_8 state counter and the latched rate word C_0..C_8.
- Accepts a rate/length configuration over a valid/ready handshake and runs the Z decode for a programmed number of X ticks.
- Signals completion with a one-cycle done pulse; sits between a host config interface and the consumer of the Z pulse train.

Parameters:
- LEN_W, 16, width of the run-length (tick count) field and remaining-tick counter.
- (Y counter width fixed at 8; rate word fixed at 9 bits C_0..C_8.)

Ports:
- CK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- cfg_valid  input  1  configuration offer.
- cfg_ready  output  1  controller accepts config (IDLE only).
- cfg_rate  input  9  rate word; bit k = C_k, k=0..8.
- cfg_len  input  LEN_W  number of X ticks to run.
- cfg_clr  input  1  clear Y counter to 0 on acceptance.
- X  input  1  tick enable.
- abort  input  1  terminate current run.
- Z  output  1  registered rate pulse.
- Y  output  8  counter state; bit k-1 = Y_k.
- busy  output  1  high in RUN.
- done  output  1  one-cycle completion pulse.
- zcount  output  LEN_W  Z pulses in current/last run (optional feature).

Behaviour:
- Reset (async, any state): state=IDLE; Y=0, rate=0, remaining=0; Z=0, busy=0, done=0, cfg_ready=1, zcount=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid&cfg_ready: latch cfg_rate and remaining=cfg_len; if cfg_clr then Y=0, else Y is kept.
  - If cfg_len!=0 go to RUN; if cfg_len==0 go straight to DONE (no ticks).
- RUN (busy=1, cfg_ready=0):
  - Each cycle with X=1, using Y before update:
    - term_0 = C_0; term_k = C_k & Y_k & (Y_1..Y_{k-1} all 0), k=1..8.
    - Z <= OR of all terms.
    - Y <= Y+1, wrapping 8'hFF -> 8'h00.
    - remaining <= remaining-1.
  - Cycle with X=0: Z <= 0; Y and remaining hold.
  - Z is registered: 1-cycle latency from the X tick.
  - When remaining decrements to 0, go to DONE.
  - abort=1 in RUN: go to DONE that cycle. The tick sampled in that same cycle is still processed (Z and Y update). abort wins over further ticks.
- DONE: done=1 for exactly one cycle, Z <= 0, then IDLE. cfg_ready=0 in DONE.
- abort outside RUN: ignored.
- cfg_valid outside IDLE: ignored, not queued.
- Rate per 256 ticks:
  - C_0 alone yields 256 pulses.
  - C_k alone (k>=1) yields 2^(8-k) pulses.
  - Terms are mutually exclusive for k>=1 (a single lowest set bit).
- Y persists across runs unless cfg_clr=1 (fractional phase continuity).
- Reset mid-RUN: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: S208_ZCOUNT_EN.
- Defined:
  - zcount clears to 0 on config acceptance.
  - Increments on each cycle Z is registered 1 during RUN; saturates at all-ones.
  - Holds after DONE until the next acceptance.
- Undefined: zcount tied to 0; no counter logic.

Test Plan:
- Reset, then cfg_rate=9'h100, cfg_len=256, cfg_clr=1, X=1 continuous:
  - exactly 1 Z pulse, registered the cycle after the Y=8'h80 tick.
  - done after 256 ticks; Y=8'h00; zcount=1.
- cfg_rate=9'h002 (C_1), cfg_len=256, cfg_clr=1:
  - 128 Z pulses, on odd Y values.
  - zcount=128.
- cfg_rate=9'h1FF, cfg_len=256, cfg_clr=1:
  - Z=1 every tick; zcount=256.
- cfg_rate=9'h010 (C_4), cfg_len=20, cfg_clr=1, X toggling 1/0:
  - ticks only on X=1; Z pulses at Y=8'h08 only.
  - done about 40 cycles after start; Y=20.
- Run with cfg_rate=9'h001, cfg_len=100; assert abort after 10 ticks:
  - DONE next; zcount=11 (abort-cycle tick counted).
  - next run with cfg_clr=0 resumes from Y=11.
- cfg_len=0: done one cycle after acceptance, no Z. Separately, RST pulsed mid-RUN: all outputs 0 asynchronously, cfg_ready=1.
